mmio_io_controller: RTL
=======================

# mmio_io_controller

Memory-mapped I/O controller between the RV32E core's data bus and the external input/output pins. It decodes core load/store requests to a small register window, buffers incoming words in a shallow FIFO, and holds outgoing words until the external sink accepts them. The core is stalled through `ready` whenever a request cannot complete. The program ROM's I/O test programs run against this block: load from 0x0 returns input, store to 0x4 drives output.

## Interface
Parameters:
- `IN_DEPTH`, 2: input FIFO depth in words; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `addr`  in  32  core byte address; only bits [3:2] are decoded, bits [1:0] ignored.
- `wdata`  in  32  core store data.
- `we`  in  1  core store request.
- `re`  in  1  core load request; `we` and `re` both high is treated as `we`.
- `rdata`  out  32  load data, valid when `re && ready`.
- `ready`  out  1  request completes this cycle; core holds request while low.
- `in_data`  in  32  external input word.
- `in_valid`  in  1  external input word offered.
- `in_ready`  out  1  FIFO can accept a word.
- `out_data`  out  32  external output word.
- `out_valid`  out  1  `out_data` pending.
- `out_ready`  in  1  external sink accepts `out_data`.

## Operation
- Register map (word index `addr[3:2]`):
  - 0 INPUT: read pops the FIFO head. Writes are ignored.
  - 1 OUTPUT: write offers `wdata` to the sink. Read returns the current `out_data`.
  - 2 STATUS: read-only `{27'b0, count[2:0], out_valid, ~empty}`, where count is the FIFO occupancy. Width-truncated if `IN_DEPTH` > 4.
  - 3 STALLS: read returns the stall counter. Any write clears it to 0.
- Input FIFO:
  - `in_ready = ~full`. A word is pushed when `in_valid && in_ready`.
  - No bypass: a word pushed while empty is readable from the next cycle.
  - A simultaneous push and pop when not full leaves count unchanged.
- INPUT read:
  - Non-empty: `ready=1` and `rdata` is the head (combinational), popped at the edge.
  - Empty: `ready=0`.
- OUTPUT write:
  - Accepted (`ready=1`) when `~out_valid`, or when `out_valid && out_ready` in the same cycle. On acceptance, `out_data<=wdata` and `out_valid<=1`.
  - Otherwise `ready=0`.
- `out_valid` clears on the edge after `out_valid && out_ready` unless a write is accepted that same cycle.
- Unmapped behaviour: every access to STATUS or STALLS, and writes to INPUT, complete with `ready=1`.
- FSM states:
  - IDLE → RD_WAIT on an INPUT read while empty.
  - IDLE → WR_WAIT on an OUTPUT write that is blocked.
  - RD_WAIT → IDLE when the FIFO is non-empty (read completes that cycle) or `re` drops (abort, no pop).
  - WR_WAIT → IDLE when the write is accepted or `we` drops (abort, no side effect).
  - The state is informational. `ready` is computed combinationally from the current request and resources in every state.
- Stall counter: 32-bit, increments every cycle with `(re||we) && ~ready`, saturates at 0xFFFF_FFFF. A write to STALLS takes priority over the increment.

## Timing
- Reset values (async on `rst_n` low): FIFO empty, `in_ready=1`, `out_valid=0`, `out_data=0`, `rdata=0` (when FIFO empty), stall counter 0, FSM IDLE.
- Zero-wait: a request with its resource available completes in the same cycle as `ready=1`, with the effect visible at the following edge.
- Read-after-push latency: `in_valid` sampled at edge N, so an INPUT read first completes in cycle N+1.
- Output latency: store accepted at edge N, so `out_valid=1` from N+1.
- Reset asserted mid-wait: the pending request is dropped and nothing is popped or latched.

## Structure
- Shared include `mmio_defs.v` holds:
  - register index constants `MMIO_INPUT=0`, `MMIO_OUTPUT=1`, `MMIO_STATUS=2`, `MMIO_STALLS=3`;
  - FSM state encodings `ST_IDLE`, `ST_RD_WAIT`, `ST_WR_WAIT`.
- One sub-module `io_input_fifo`, parameterised by `IN_DEPTH`, with ports push/pop/head/count/full/empty.
- Decode, output holding register, FSM and stall counter stay in the top level.

## Test plan
- Reset: hold `rst_n=0` with `in_valid=1` → `in_ready=1`, `out_valid=0`, STATUS reads 0 after release, FIFO empty.
- Push 7 then 9, then read INPUT twice → `rdata` 7 then 9, `ready=1` both cycles, STATUS ends 0.
- Read INPUT while empty for 3 cycles, then push 5 → `ready=0` for 4 cycles, `rdata=5` on the completing cycle, STALLS reads 4.
- Store 2 to OUTPUT with `out_ready=0`, then store 3 → second store stalls until `out_ready=1`. Completes that cycle; `out_data=3`, `out_valid` stays 1.
- Push with `IN_DEPTH=2` until full → `in_ready=0`, third word not accepted. After a pop, `in_ready=1` next cycle.
- RD_WAIT then pulse `rst_n` low → FSM IDLE, counter 0, no pop. Write to STALLS clears a nonzero count to 0.

Source files
------------

// File: rtl/mmio_io_controller_pkg.sv
// Shared definitions for the MMIO I/O controller: register indices and FSM states.
package mmio_io_controller_pkg;

    localparam logic [1:0] MMIO_INPUT  = 2'd0;
    localparam logic [1:0] MMIO_OUTPUT = 2'd1;
    localparam logic [1:0] MMIO_STATUS = 2'd2;
    localparam logic [1:0] MMIO_STALLS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mmio_io_controller_if.sv
// Core data-bus request/response plus the external input/output pin handshakes.
interface mmio_io_controller_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output addr, wdata, we, re, in_data, in_valid, out_ready,
        input  rdata, ready, in_ready, out_data, out_valid
    );

    modport slave (
        input  addr, wdata, we, re, in_data, in_valid, out_ready,
        output rdata, ready, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mmio_io_controller_io_input_fifo.sv
// Shallow input FIFO; no bypass, so a pushed word is visible at head from the next cycle.
module io_input_fifo #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [31:0]   push_data_i,
    input  logic          pop_i,
    output logic [31:0]   head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mmio_io_controller.sv
// MMIO I/O controller: register decode, input FIFO, output holding register,
// wait-state FSM and stall counter.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_IDLE    | no request waiting
//   ST_RD_WAIT | INPUT read held off because the FIFO is empty
//   ST_WR_WAIT | OUTPUT write held off because the sink is busy
//
// The state is informational only; ready is derived from the live request.
module mmio_io_controller
    import mmio_io_controller_pkg::*;
#(
    parameter int IN_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mmio_io_controller_if.slave bus
);

    localparam int CW = $clog2(IN_DEPTH) + 1;
    localparam int SW = (CW < 3) ? CW : 3;

    logic [1:0]    idx;
    logic          wr_req, rd_req;
    logic          out_accept, wr_out, pop, push;
    logic          ready_c, stall_evt;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [2:0]    count3;
    logic          unused_addr;

    logic [31:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   stall_q, stall_d;
    state_t        state_q, state_d;

    assign idx         = bus.addr[3:2];
    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
    assign wr_req      = bus.we;
    assign rd_req      = bus.re & ~bus.we;
    assign out_accept  = ~out_valid_q | bus.out_ready;
    assign wr_out      = wr_req && (idx == MMIO_OUTPUT) && out_accept;
    assign pop         = rd_req && (idx == MMIO_INPUT) && ~fifo_empty;
    assign push        = bus.in_valid & ~fifo_full;
    assign count3      = 3'(fifo_count[SW-1:0]);

    io_input_fifo #(.DEPTH(IN_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (bus.in_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Request completion: only INPUT reads and OUTPUT writes can wait.
    always_comb begin
        ready_c = 1'b1;
        if (wr_req) begin
            if (idx == MMIO_OUTPUT) ready_c = out_accept;
        end else if (rd_req) begin
            if (idx == MMIO_INPUT) ready_c = ~fifo_empty;
        end
    end

    assign stall_evt = (bus.re | bus.we) & ~ready_c;

    // Read data mux; zero when no load is requested or the FIFO is empty.
    always_comb begin
        bus.rdata = 32'd0;
        if (bus.re) begin
            case (idx)
                MMIO_INPUT:  bus.rdata = fifo_empty ? 32'd0 : fifo_head;
                MMIO_OUTPUT: bus.rdata = out_data_q;
                MMIO_STATUS: bus.rdata = {27'd0, count3, out_valid_q, ~fifo_empty};
                default:     bus.rdata = stall_q;
            endcase
        end
    end

    // Output holding register and stall counter next-state.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        stall_d     = stall_q;
        if (wr_out) begin
            out_data_d  = bus.wdata;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (wr_req && (idx == MMIO_STALLS)) begin
            stall_d = 32'd0;
        end else if (stall_evt && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req && (idx == MMIO_INPUT) && fifo_empty)
                    state_d = ST_RD_WAIT;
                else if (wr_req && (idx == MMIO_OUTPUT) && ~out_accept)
                    state_d = ST_WR_WAIT;
            end
            ST_RD_WAIT: begin
                if (~fifo_empty || ~(rd_req && (idx == MMIO_INPUT)))
                    state_d = ST_IDLE;
            end
            ST_WR_WAIT: begin
                if (out_accept || ~(wr_req && (idx == MMIO_OUTPUT)))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            stall_q     <= 32'd0;
            state_q     <= ST_IDLE;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
            state_q     <= state_d;
        end
    end

    assign bus.ready     = ready_c;
    assign bus.in_ready  = ~fifo_full;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule
